reqack_tph2rdyval: RTL



---
 rtl/reqack_tph2rdyval.sv | 92 +++++++++
 1 files changed

// File: rtl/reqack_tph2rdyval.sv
// Two-phase request/acknowledge receiver presenting a ready/valid stream.
// A toggle on req (after optional 2-flop synchronisation) announces a new
// word on i_dat. The word is captured into a single output register and
// acknowledged with an ack toggle at the same edge, so the sender can run
// ahead while the captured word waits for rdy.
module reqack_tph2rdyval #(
  parameter int unsigned DWIDTH      = 1,
  parameter bit          INCLUDE_CDC = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              ack,
  input  logic [DWIDTH-1:0] i_dat,
  output logic              vld,
  input  logic              rdy,
  output logic [DWIDTH-1:0] o_dat
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ack;
  logic              w_ack_nxt;
  logic              r_sync_p0;
  logic              r_sync_p1;
  logic [DWIDTH-1:0] r_dat_p0;
  logic              w_req_i;
  logic              w_pending;
  logic              w_cap;

  // --- stage 0: req synchroniser (bypassed when the sender shares clk) ---
  // Two-flop synchroniser on the incoming request level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= req;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_req_i   = INCLUDE_CDC ? r_sync_p1 : req;

  // A request is outstanding whenever the request level differs from ack.
  assign w_pending = w_req_i ^ r_ack;

  // Capture when the output slot is empty or being drained this edge;
  // a simultaneous pop and capture keeps one transfer per cycle.
  assign w_cap     = w_pending & ((r_state == S_EMPTY) | rdy);

  // Next state of the output slot and the acknowledge toggle.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    if (w_cap) begin
      w_state_nxt = S_FULL;
      w_ack_nxt   = ~r_ack;
    end else if ((r_state == S_FULL) && rdy) begin
      w_state_nxt = S_EMPTY;
    end
  end

  // --- stage 1: output slot control ---
  // Slot occupancy and acknowledge registers; reset empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // Output data register; only meaningful while vld is high, so no reset.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_dat_p0 <= i_dat;
    end
  end

  assign vld   = (r_state == S_FULL);
  assign ack   = r_ack;
  assign o_dat = r_dat_p0;

endmodule
